// File: rtl/ipm_fifo_pkg.sv
// Shared definitions for the distributed-RAM FIFO family: read-mode names,
// count width helper and the FWFT output-stage state encoding.
package ipm_fifo_pkg;

  localparam string RM_STD  = "STD";
  localparam string RM_FWFT = "FWFT";

  typedef enum logic {
    FWFT_EMPTY = 1'b0,
    FWFT_VALID = 1'b1
  } fwft_state_e;

  function automatic int unsigned cnt_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/ipm_dist_sdpram_1clk.sv
// Single-clock distributed simple-dual-port RAM: registered write port,
// combinational read port. Contents are intentionally not reset.
module ipm_dist_sdpram_1clk #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ipm_distributed_sync_fifo_v1_0.sv
// Single-clock FIFO over a distributed SDPRAM with registered flags, occupancy
// count, sticky error flags and STD or first-word-fall-through read mode.
module ipm_distributed_sync_fifo_v1_0
  import ipm_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter string       READ_MODE  = "STD",
  parameter int unsigned AFULL_TH   = (2**ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  wr_full,
  output logic                  wr_afull,
  output logic                  rd_empty,
  output logic                  rd_aempty,
  output logic [ADDR_WIDTH:0]   data_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned   DEPTH    = 2**ADDR_WIDTH;
  localparam int unsigned   PW       = ADDR_WIDTH + 1;
  localparam int unsigned   CW       = cnt_width(ADDR_WIDTH);
  localparam bit            IS_FWFT  = (READ_MODE == RM_FWFT);
  localparam logic [CW-1:0] AFULL_V  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_V = CW'(AEMPTY_TH);

  initial begin
    if (ADDR_WIDTH < 4 || ADDR_WIDTH > 10)
      $error("ADDR_WIDTH %0d outside 4..10", ADDR_WIDTH);
    if (AFULL_TH > DEPTH)
      $error("AFULL_TH %0d exceeds DEPTH %0d", AFULL_TH, DEPTH);
    if (AEMPTY_TH >= AFULL_TH)
      $error("AEMPTY_TH %0d must be below AFULL_TH %0d", AEMPTY_TH, AFULL_TH);
    if (READ_MODE != RM_STD && READ_MODE != RM_FWFT)
      $error("READ_MODE must be STD or FWFT");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]         cnt_nxt;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  wr_acc, ram_pop, ram_empty, rd_rej;
  logic                  full_nxt, rd_empty_nxt, rd_valid_nxt;
  fwft_state_e           state, state_nxt;

  ipm_dist_sdpram_1clk #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data(wr_data),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(ram_rd_data)
  );

  // wr_full tracks the RAM only; in FWFT the output stage holds one more word,
  // so data_cnt can reach DEPTH+1 there.
  always_comb begin
    wr_acc    = wr_en && !wr_full;
    ram_empty = (wr_ptr == rd_ptr);
    state_nxt = state;
    ram_pop   = 1'b0;
    rd_rej    = 1'b0;
    if (IS_FWFT) begin
      rd_rej = rd_en && (state == FWFT_EMPTY);
      case (state)
        FWFT_EMPTY: if (!ram_empty) begin
          ram_pop   = 1'b1;
          state_nxt = FWFT_VALID;
        end
        FWFT_VALID: if (rd_en) begin
          if (!ram_empty) ram_pop   = 1'b1;
          else            state_nxt = FWFT_EMPTY;
        end
      endcase
    end else begin
      rd_rej  = rd_en && rd_empty;
      ram_pop = rd_en && !rd_empty;
    end

    wr_ptr_nxt   = wr_ptr + PW'(wr_acc);
    rd_ptr_nxt   = rd_ptr + PW'(ram_pop);
    full_nxt     = (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]) &&
                   (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]);
    cnt_nxt      = CW'(wr_ptr_nxt - rd_ptr_nxt) +
                   CW'(IS_FWFT && (state_nxt == FWFT_VALID));
    rd_empty_nxt = IS_FWFT ? (state_nxt == FWFT_EMPTY) : (wr_ptr_nxt == rd_ptr_nxt);
    rd_valid_nxt = IS_FWFT ? (state_nxt == FWFT_VALID) : ram_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FWFT_EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_cnt  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      wr_full   <= 1'b0;
      wr_afull  <= 1'b0;
      rd_empty  <= 1'b1;
      rd_aempty <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      data_cnt  <= cnt_nxt;
      rd_valid  <= rd_valid_nxt;
      wr_full   <= full_nxt;
      wr_afull  <= (cnt_nxt >= AFULL_V);
      rd_empty  <= rd_empty_nxt;
      rd_aempty <= (cnt_nxt <= AEMPTY_V);
      if (ram_pop)          rd_data   <= ram_rd_data;
      if (wr_en && wr_full) overflow  <= 1'b1;
      if (rd_rej)           underflow <= 1'b1;
    end
  end

endmodule
